// File: rtl/seq_div16_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t   : FSM encoding (idle / busy / done)
//   DEF_WIDTH : default operand, quotient and remainder width
package seq_div16_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/seq_div16_cla_sub.sv
// Combinational carry-lookahead subtractor: diff = a - b.
// The subtrahend is inverted and the carry-in is forced to 1 (two's
// complement), and each carry is built directly from the generate/propagate
// terms instead of rippling through the previous carry.
// Ports:
//   a      in  N  minuend
//   b      in  N  subtrahend
//   diff   out N  a - b (modulo 2^N)
//   borrow out 1  high when b > a (inverted carry out)
module cla_sub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] b_inv;
  logic [N-1:0] prop;
  logic [N-1:0] gen;
  logic [N:0]   carry;

  assign b_inv = ~b;
  assign prop  = a ^ b_inv;
  assign gen   = a & b_inv;

  // carry[i] = OR_j ( gen[j] & prop[j+1..i-1] )  |  prop[0..i-1] & cin, with cin = 1
  always_comb begin
    logic run;
    logic acc;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i <= N; i++) begin
      acc = 1'b0;
      for (int j = 0; j < i; j++) begin
        run = gen[j];
        for (int k = j + 1; k < i; k++) begin
          run = run & prop[k];
        end
        acc = acc | run;
      end
      run = 1'b1;
      for (int k = 0; k < i; k++) begin
        run = run & prop[k];
      end
      carry[i] = acc | run;
    end
  end

  assign diff   = prop ^ carry[N-1:0];
  assign borrow = ~carry[N];

endmodule

// File: rtl/seq_div16.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock.
// A request is taken over a valid/ready port, the result is presented on a
// valid/ready port and held until the consumer takes it.
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   in_valid     in   1      request valid
//   in_ready     out  1      divider idle; request accepted when in_valid is high
//   dividend     in   WIDTH  unsigned dividend, sampled on accept
//   divisor      in   WIDTH  unsigned divisor, sampled on accept
//   out_valid    out  1      result valid, held until out_ready
//   out_ready    in   1      result consumer ready
//   quot         out  WIDTH  quotient ('1 for a zero divisor)
//   rem          out  WIDTH  remainder (dividend for a zero divisor)
//   div_by_zero  out  1      result came from a zero divisor
module seq_div16
  import seq_div16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_step;
  logic [CNT_W-1:0] cnt;

  // Datapath: partial remainder, divisor copy, and a combined shift register
  // whose upper bits hold the unconsumed dividend and whose lower bits collect
  // the quotient as it is produced.
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dq_sh;

  logic [WIDTH:0]   sub_a;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             q_bit;
  logic [WIDTH-1:0] part_nxt;
  logic             unused_diff_msb;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt == '0) begin
          last_step = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The dividend MSB is tried on the accept edge straight from the input
  // port, so BUSY only has WIDTH-1 bits left to process and the subtractor
  // is shared between the two cases.
  always_comb begin
    if (state == S_BUSY) begin
      sub_a = {part_rem, dq_sh[WIDTH-1]};
      sub_b = {1'b0, dvs};
    end else begin
      sub_a = {{WIDTH{1'b0}}, dividend[WIDTH-1]};
      sub_b = {1'b0, divisor};
    end
  end

  cla_sub #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (sub_a),
    .b      (sub_b),
    .diff   (diff),
    .borrow (borrow)
  );

  // Partial remainder stays below the divisor, so a borrow-free difference
  // always fits in WIDTH bits and its top bit is never needed.
  assign q_bit           = ~borrow;
  assign part_nxt        = borrow ? sub_a[WIDTH-1:0] : diff[WIDTH-1:0];
  assign unused_diff_msb = diff[WIDTH];

  // Bit counter: index of the dividend bit handled in the current BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(WIDTH - 2);
    end else if (state == S_BUSY && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Iteration registers
  always_ff @(posedge clk) begin
    if (accept) begin
      dvs      <= divisor;
      part_rem <= part_nxt;
      dq_sh    <= {dividend[WIDTH-2:0], q_bit};
    end else if (state == S_BUSY) begin
      part_rem <= part_nxt;
      dq_sh    <= {dq_sh[WIDTH-2:0], q_bit};
    end
  end

  // Result registers, stable for the whole DONE state
  always_ff @(posedge clk) begin
    if (rst) begin
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && divisor == '0) begin
      quot        <= '1;
      rem         <= dividend;
      div_by_zero <= 1'b1;
    end else if (last_step) begin
      quot        <= {dq_sh[WIDTH-2:0], q_bit};
      rem         <= part_nxt;
      div_by_zero <= 1'b0;
    end
  end

endmodule
